// File: rtl/instr_pkg.sv
// Shared definitions for the 9-bit instruction fetch path: word layout,
// the NOP encoding and the loader FSM states.
package instr_pkg;

  localparam int INSTR_W     = 9;
  localparam int FORMAT_BIT  = 8;
  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 4;
  localparam int SIGN_BIT    = 3;
  localparam int OPERAND_MSB = 2;
  localparam int OPERAND_LSB = 0;

  localparam logic [INSTR_W-1:0] NOP_WORD = 9'b000000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/instr_field_split.sv
// Pure combinational slicer from a 9-bit instruction word to its decode fields;
// the same slicer sits behind every fetch path so they all decode identically.
module instr_field_split
  import instr_pkg::*;
(
  input  logic [INSTR_W-1:0] word,
  output logic               format,
  output logic [3:0]         opcode,
  output logic               sign,
  output logic [2:0]         operand,
  output logic [7:0]         immediate
);

  assign format    = word[FORMAT_BIT];
  assign opcode    = word[OPCODE_MSB:OPCODE_LSB];
  assign sign      = word[SIGN_BIT];
  assign operand   = word[OPERAND_MSB:OPERAND_LSB];
  assign immediate = word[OPCODE_MSB:0];

endmodule

// File: rtl/instr_loader.sv
// Writable instruction store: a valid/ready stream fills it from address 0,
// and the core reads it combinationally through the ROM-compatible field port.
module instr_loader
  import instr_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               loaded,
  output logic               load_error,
  output logic [AW:0]        load_count,
  input  logic [15:0]        pc_in,
  output logic               format,
  output logic [3:0]         opcode,
  output logic               sign,
  output logic [2:0]         operand,
  output logic [7:0]         immediate
);

  // Handshake: a word transfers on a rising edge where load_valid and
  // load_ready are both high; load_data/load_last are only looked at then,
  // and anything offered while load_ready is low is dropped, not held.

  load_state_t state, state_next;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] word;
  logic handshake;
  logic at_last_slot;
  logic restart;

  assign handshake    = load_valid & load_ready;
  assign at_last_slot = (load_count == (AW+1)'(DEPTH - 1));
  assign restart      = start & ((state == ST_IDLE) | (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: if (handshake && (load_last || at_last_slot)) state_next = ST_DONE;
      ST_DONE: if (start) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == ST_LOAD) && (load_count < (AW+1)'(DEPTH));
    loaded     = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_count <= '0;
      load_error <= 1'b0;
    end else if (restart) begin
      load_count <= '0;
      load_error <= 1'b0;
    end else if (handshake) begin
      load_count <= load_count + (AW+1)'(1);
      if (!load_last && at_last_slot) load_error <= 1'b1;
    end
  end

  // Storage is deliberately not reset; load_count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (handshake) mem[load_count[AW-1:0]] <= load_data;
  end

  // Addresses at or beyond DEPTH always fail the count compare, so no aliasing.
  assign word = (pc_in < 16'(load_count)) ? mem[pc_in[AW-1:0]] : NOP_WORD;

  instr_field_split u_split (
    .word      (word),
    .format    (format),
    .opcode    (opcode),
    .sign      (sign),
    .operand   (operand),
    .immediate (immediate)
  );

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized load sessions checked against
// an array-and-count model of the store.
module tb_instr_loader;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int W     = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          load_valid;
  logic [W-1:0]  load_data;
  logic          load_last;
  logic          load_ready;
  logic          loaded;
  logic          load_error;
  logic [AW:0]   load_count;
  logic [15:0]   pc_in;
  logic          format;
  logic [3:0]    opcode;
  logic          sign;
  logic [2:0]    operand;
  logic [7:0]    immediate;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] model_mem [DEPTH];
  int           model_count;
  logic         model_error;
  logic [W-1:0] exp_q [$];

  instr_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .loaded     (loaded),
    .load_error (load_error),
    .load_count (load_count),
    .pc_in      (pc_in),
    .format     (format),
    .opcode     (opcode),
    .sign       (sign),
    .operand    (operand),
    .immediate  (immediate)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read: only words below the session count are visible.
  function automatic logic [W-1:0] model_word(input logic [15:0] pc);
    if (int'(pc) < model_count) return model_mem[pc[AW-1:0]];
    return '0;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_count = 0;
    model_error = 1'b0;
  endtask

  // Offers one word and waits (bounded) for it to be accepted.
  task automatic send_word(input logic [W-1:0] data, input logic last);
    int waited = 0;
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    while (!load_ready && waited < 10) begin
      tick();
      waited++;
    end
    vectors++;
    if (!load_ready) begin
      miscompares++;
      $display("FAIL send_timeout: load_ready=%0b required=1", load_ready);
    end else begin
      tick();
      model_mem[model_count] = data;
      model_count++;
      if (!last && model_count == DEPTH) model_error = 1'b1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] obs;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_count = 0;
    model_error = 1'b0;
    pc_in = 16'd0;
    #1;
    obs = {format, opcode, sign, operand};
    vectors++;
    if (load_ready !== 1'b0 || loaded !== 1'b0 || load_error !== 1'b0 || load_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%0b loaded=%0b err=%0b count=%0d required 0 0 0 0",
               load_ready, loaded, load_error, load_count);
    end
    vectors++;
    if (obs !== 9'd0 || immediate !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_read: word=%h imm=%h required 000 00", obs, immediate);
    end
  endtask

  task automatic test_basic_load();
    logic [W-1:0] obs;
    do_start();
    vectors++;
    if (load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_ready_after_start: ready=%0b required=1", load_ready);
    end
    send_word(9'h000, 1'b0);
    send_word(9'h178, 1'b0);
    send_word(9'h080, 1'b1);
    vectors++;
    if (loaded !== 1'b1 || load_ready !== 1'b0 || load_count !== 8'd3 || load_error !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: loaded=%0b ready=%0b count=%0d err=%0b required 1 0 3 0",
               loaded, load_ready, load_count, load_error);
    end
    pc_in = 16'd1;
    #1;
    vectors++;
    if (format !== 1'b1 || opcode !== 4'b0111 || sign !== 1'b1 || operand !== 3'b000 ||
        immediate !== 8'h78) begin
      miscompares++;
      $display("FAIL basic_fields_pc1: f=%0b op=%b s=%0b opd=%b imm=%h required 1 0111 1 000 78",
               format, opcode, sign, operand, immediate);
    end
    pc_in = 16'd3;
    #1;
    obs = {format, opcode, sign, operand};
    vectors++;
    if (obs !== 9'd0 || immediate !== 8'd0) begin
      miscompares++;
      $display("FAIL basic_read_pc3: word=%h imm=%h required 000 00", obs, immediate);
    end
  endtask

  task automatic test_gaps();
    int n;
    logic [W-1:0] obs, exp_w;
    do_start();
    n = $urandom_range(4, 12);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        load_data = W'($urandom);
        tick();
      end
      exp_q.push_back(W'($urandom));
      send_word(exp_q[$], i == n - 1);
      vectors++;
      if (int'(load_count) !== i + 1) begin
        miscompares++;
        $display("FAIL gaps_count: count=%0d required=%0d", load_count, i + 1);
      end
    end
    for (int a = 0; a < n + 3; a++) begin
      pc_in = 16'(a);
      #1;
      obs = {format, opcode, sign, operand};
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
      vectors++;
      if (obs !== exp_w || immediate !== exp_w[7:0]) begin
        miscompares++;
        $display("FAIL gaps_read pc=%0d: word=%h required=%h", a, obs, exp_w);
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] obs, exp_w;
    logic [15:0] pc;
    do_start();
    for (int i = 0; i < DEPTH; i++) send_word(W'($urandom), 1'b0);
    vectors++;
    if (loaded !== 1'b1 || load_error !== model_error || int'(load_count) !== model_count ||
        load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_done: loaded=%0b err=%0b count=%0d ready=%0b required 1 %0b %0d 0",
               loaded, load_error, load_count, load_ready, model_error, model_count);
    end
    load_valid = 1'b1;
    load_data  = ~model_mem[0];
    tick();
    load_valid = 1'b0;
    pc_in = 16'd0;
    #1;
    obs = {format, opcode, sign, operand};
    exp_w = model_word(16'd0);
    vectors++;
    if (load_count !== 8'd128 || obs !== exp_w) begin
      miscompares++;
      $display("FAIL overflow_extra_word: count=%0d word0=%h required 128 %h", load_count, obs, exp_w);
    end
    for (int i = 0; i < 24; i++) begin
      pc = (i < 4) ? 16'(128 + i) : ((i < 8) ? 16'($urandom) : 16'($urandom_range(0, 127)));
      pc_in = pc;
      #1;
      obs = {format, opcode, sign, operand};
      exp_w = model_word(pc);
      vectors++;
      if (obs !== exp_w || immediate !== exp_w[7:0]) begin
        miscompares++;
        $display("FAIL overflow_read pc=%h: word=%h required=%h", pc, obs, exp_w);
      end
    end
  endtask

  task automatic test_reload();
    logic [W-1:0] obs;
    start      = 1'b1;
    load_valid = 1'b1;
    load_data  = 9'h1ff;
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    model_count = 0;
    model_error = 1'b0;
    vectors++;
    if (load_count !== 8'd0 || load_ready !== 1'b1 || load_error !== 1'b0 || loaded !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_start: count=%0d ready=%0b err=%0b loaded=%0b required 0 1 0 0",
               load_count, load_ready, load_error, loaded);
    end
    send_word(W'($urandom), 1'b0);
    send_word(W'($urandom), 1'b1);
    vectors++;
    if (load_count !== 8'd2 || load_error !== 1'b0 || loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_done: count=%0d err=%0b loaded=%0b required 2 0 1",
               load_count, load_error, loaded);
    end
    for (int a = 0; a < 3; a++) begin
      pc_in = 16'(a);
      #1;
      obs = {format, opcode, sign, operand};
      vectors++;
      if (obs !== model_word(16'(a))) begin
        miscompares++;
        $display("FAIL reload_read pc=%0d: word=%h required=%h", a, obs, model_word(16'(a)));
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [W-1:0] obs;
    do_start();
    for (int i = 0; i < 5; i++) send_word(W'($urandom_range(1, 511)), 1'b0);
    vectors++;
    if (load_count !== 8'd5) begin
      miscompares++;
      $display("FAIL midload_count: count=%0d required=5", load_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_count = 0;
    pc_in = 16'd0;
    #1;
    obs = {format, opcode, sign, operand};
    vectors++;
    if (load_ready !== 1'b0 || load_count !== 8'd0 || loaded !== 1'b0 || obs !== 9'd0) begin
      miscompares++;
      $display("FAIL midload_reset: ready=%0b count=%0d loaded=%0b word=%h required 0 0 0 000",
               load_ready, load_count, loaded, obs);
    end
  endtask

  task automatic test_read_during_write();
    logic [W-1:0] obs, data;
    do_start();
    for (int k = 0; k < 4; k++) begin
      data = 9'h100 | W'($urandom);
      pc_in = 16'(k);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = (k == 3);
      #1;
      obs = {format, opcode, sign, operand};
      vectors++;
      if (obs !== 9'd0) begin
        miscompares++;
        $display("FAIL rdw_same_cycle pc=%0d: word=%h required=000", k, obs);
      end
      tick();
      model_mem[model_count] = data;
      model_count++;
      load_valid = 1'b0;
      load_last  = 1'b0;
      obs = {format, opcode, sign, operand};
      vectors++;
      if (obs !== data) begin
        miscompares++;
        $display("FAIL rdw_next_cycle pc=%0d: word=%h required=%h", k, obs, data);
      end
    end
    pc_in = 16'h0080;
    #1;
    obs = {format, opcode, sign, operand};
    vectors++;
    if (obs !== 9'd0 || immediate !== 8'd0 || loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL rdw_pc_0080: word=%h imm=%h loaded=%0b required 000 00 1", obs, immediate, loaded);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    load_valid = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    pc_in = '0;
    model_count = 0;
    model_error = 1'b0;
    test_reset();
    test_basic_load();
    test_gaps();
    test_overflow();
    test_reload();
    test_reset_mid_load();
    test_read_during_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
